sample_sched: RTL
=================

SAMPLE_SCHED -- requirements
Module: sample_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of ADC sample, compute operand and DAC word.
REQ-002 SHALL have parameter TIMEOUT, default 255, max design_clk cycles allowed in RUN before abort (legal 1..1023).
REQ-003 SHALL have ports:
- design_clk  in  1  sole clock, rising edge
- design_n_rst  in  1  asynchronous active-low reset
- en  in  1  level; 0 blocks new acquisitions
- adc_tdata  in  DATA_W  ADC sample pair {ch1,ch2}
- adc_tvalid  in  1  ADC sample valid
- adc_tready  out  1  scheduler accepts sample
- cmp_start  out  1  one-cycle start pulse to compute block
- cmp_x  out  DATA_W  registered operand to compute block
- cmp_done  in  1  one-cycle completion pulse from compute block
- cmp_y  in  DATA_W  compute result, valid with cmp_done
- dac_tdata  out  DATA_W  result to DAC interface
- dac_tvalid  out  1  result valid
- dac_tready  in  1  DAC accepts result
- ovr_cnt  out  16  dropped-sample count, saturating
- to_cnt  out  8  compute-timeout count, saturating
- state  out  2  FSM state (IDLE=0, RUN=1, PUSH=2)

Function
REQ-004 SHALL implement FSM IDLE -> RUN -> PUSH -> IDLE; encoding 3 unused, decodes to IDLE next cycle.
REQ-005 In IDLE, adc_tready SHALL equal en; handshake (adc_tvalid & adc_tready) at edge N SHALL load cmp_x, pulse cmp_start for cycle N+1 only, enter RUN.
REQ-006 In RUN, a watchdog SHALL count from 0 each cycle; cmp_done SHALL capture cmp_y into dac_tdata, assert dac_tvalid next cycle, enter PUSH.
REQ-007 If watchdog reaches TIMEOUT without cmp_done, FSM SHALL return to IDLE, increment to_cnt, leave dac_tdata/dac_tvalid unchanged; a cmp_done arriving the same cycle as timeout SHALL win (no timeout counted).
REQ-008 cmp_done outside RUN SHALL be ignored.
REQ-009 In PUSH, dac_tvalid SHALL stay 1 and dac_tdata stable until dac_tvalid & dac_tready; dac_tvalid SHALL drop the following cycle.
REQ-010 Outside IDLE, adc_tready SHALL be 1 (ADC cannot stall); each handshake there SHALL be an overrun handled per REQ-016/017.
REQ-011 ovr_cnt and to_cnt SHALL saturate at 0xFFFF and 0xFF respectively, never wrap.
REQ-012 en deasserted in RUN or PUSH SHALL not abort the in-flight sample; FSM completes to IDLE and waits.
REQ-013 Minimum sample-to-DAC latency: handshake edge N, cmp_done at edge M, dac_tvalid high from cycle M+1.

Reset
REQ-014 design_n_rst low SHALL asynchronously force state=IDLE, cmp_start=0, cmp_x=0, dac_tdata=0, dac_tvalid=0, ovr_cnt=0, to_cnt=0, watchdog=0, hold register empty.
REQ-015 Reset mid-RUN or mid-PUSH SHALL discard the sample; adc_tready SHALL follow en from first cycle after release.

Configuration
REQ-016 Without SAMPLE_SCHED_HOLD_EN: every handshake outside IDLE SHALL be dropped and increment ovr_cnt.
REQ-017 With SAMPLE_SCHED_HOLD_EN: one holding register SHALL store the first sample accepted outside IDLE; later ones overwrite it and increment ovr_cnt; on PUSH completion with hold full and en=1, FSM SHALL go directly to RUN pulsing cmp_start with held sample next cycle and clear hold; en=0 at that point SHALL discard hold and increment ovr_cnt.

Verification
REQ-018 en=1, ADC sample 0x1234_5678, cmp_done 4 cycles after cmp_start with cmp_y=0xCAFE_0001, dac_tready=1 -> one cmp_start, dac_tdata=0xCAFE_0001 one cycle, ovr_cnt=0.
REQ-019 dac_tready=0 for 10 cycles in PUSH -> dac_tvalid and dac_tdata held 10 cycles, single transfer on release.
REQ-020 cmp_done never returned, TIMEOUT=8 -> state back to IDLE after 8 RUN cycles, to_cnt=1, dac_tvalid never asserted.
REQ-021 adc_tvalid every cycle, compute latency 5 -> without macro ovr_cnt increments on every non-IDLE handshake; with macro back-to-back RUN using last held sample.
REQ-022 design_n_rst pulsed low during PUSH -> all outputs to reset values immediately, next sample processes normally.

Source files
------------

// File: rtl/sample_sched.sv
// ADC -> compute -> DAC sample scheduler with a compute watchdog and saturating overrun/timeout counters.
// Define SAMPLE_SCHED_HOLD_EN to keep one sample captured while busy and launch it straight after PUSH.
module sample_sched #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              design_clk,
   input  logic              design_n_rst,
   input  logic              en,
   input  logic [DATA_W-1:0] adc_tdata,
   input  logic              adc_tvalid,
   output logic              adc_tready,
   output logic              cmp_start,
   output logic [DATA_W-1:0] cmp_x,
   input  logic              cmp_done,
   input  logic [DATA_W-1:0] cmp_y,
   output logic [DATA_W-1:0] dac_tdata,
   output logic              dac_tvalid,
   input  logic              dac_tready,
   output logic [15:0]       ovr_cnt,
   output logic [7:0]        to_cnt,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PUSH = 2'd2} state_t;
   localparam logic [9:0] TIMEOUT_W = 10'(TIMEOUT);

   state_t            state_q, state_d;
   logic              cmp_start_q, cmp_start_d;
   logic [DATA_W-1:0] cmp_x_q, cmp_x_d;
   logic [DATA_W-1:0] dac_tdata_q, dac_tdata_d;
   logic              dac_tvalid_q, dac_tvalid_d;
   logic [15:0]       ovr_cnt_q, ovr_cnt_d;
   logic [7:0]        to_cnt_q, to_cnt_d;
   logic [9:0]        wdog_q, wdog_d;
   logic              hold_full_q, hold_full_d;
   logic [DATA_W-1:0] hold_q, hold_d;

   logic              busy_hs;
   logic              wdog_exp;
   logic              push_done;
   logic              take_full;
   logic [DATA_W-1:0] take_data;
   logic [1:0]        ovr_inc;
   logic [16:0]       ovr_sum;

   // Outside IDLE the ADC is never stalled; anything accepted there is an overrun candidate.
   assign adc_tready = (state_q == IDLE) ? en : 1'b1;

   always_comb begin
      state_d      = state_q;
      cmp_start_d  = 1'b0;
      cmp_x_d      = cmp_x_q;
      dac_tdata_d  = dac_tdata_q;
      dac_tvalid_d = dac_tvalid_q;
      to_cnt_d     = to_cnt_q;
      wdog_d       = wdog_q;
      hold_full_d  = hold_full_q;
      hold_d       = hold_q;
      ovr_inc      = 2'd0;
      busy_hs      = adc_tvalid && (state_q != IDLE);
      wdog_exp     = (wdog_q + 10'd1) >= TIMEOUT_W;
      push_done    = dac_tvalid_q && dac_tready;
`ifdef SAMPLE_SCHED_HOLD_EN
      // take_* is the hold contents including a sample arriving on this very edge (newest wins).
      take_full = hold_full_q || busy_hs;
      take_data = busy_hs ? adc_tdata : hold_q;
      if (busy_hs) begin
         hold_full_d = 1'b1;
         hold_d      = adc_tdata;
         if (hold_full_q) ovr_inc = 2'd1;
      end
`else
      take_full = 1'b0;
      take_data = hold_q;
      if (busy_hs) ovr_inc = 2'd1;
`endif
      case (state_q)
         IDLE: begin
            if (adc_tvalid && en) begin
               cmp_x_d     = adc_tdata;
               cmp_start_d = 1'b1;
               wdog_d      = 10'd0;
               state_d     = RUN;
            end
         end
         RUN: begin
            wdog_d = wdog_q + 10'd1;
            if (cmp_done) begin
               dac_tdata_d  = cmp_y;
               dac_tvalid_d = 1'b1;
               state_d      = PUSH;
            end else if (wdog_exp) begin
               wdog_d  = 10'd0;
               state_d = IDLE;
               if (to_cnt_q != 8'hFF) to_cnt_d = to_cnt_q + 8'd1;
               if (take_full) begin
                  hold_full_d = 1'b0;
                  ovr_inc     = ovr_inc + 2'd1;
               end
            end
         end
         PUSH: begin
            if (push_done) begin
               dac_tvalid_d = 1'b0;
               state_d      = IDLE;
               if (take_full) begin
                  hold_full_d = 1'b0;
                  if (en) begin
                     cmp_x_d     = take_data;
                     cmp_start_d = 1'b1;
                     wdog_d      = 10'd0;
                     state_d     = RUN;
                  end else begin
                     ovr_inc = ovr_inc + 2'd1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
      ovr_sum   = {1'b0, ovr_cnt_q} + {15'd0, ovr_inc};
      ovr_cnt_d = ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];
   end

   always_ff @(posedge design_clk or negedge design_n_rst) begin
      if (!design_n_rst) begin
         state_q      <= IDLE;
         cmp_start_q  <= 1'b0;
         cmp_x_q      <= '0;
         dac_tdata_q  <= '0;
         dac_tvalid_q <= 1'b0;
         ovr_cnt_q    <= 16'd0;
         to_cnt_q     <= 8'd0;
         wdog_q       <= 10'd0;
         hold_full_q  <= 1'b0;
         hold_q       <= '0;
      end else begin
         state_q      <= state_d;
         cmp_start_q  <= cmp_start_d;
         cmp_x_q      <= cmp_x_d;
         dac_tdata_q  <= dac_tdata_d;
         dac_tvalid_q <= dac_tvalid_d;
         ovr_cnt_q    <= ovr_cnt_d;
         to_cnt_q     <= to_cnt_d;
         wdog_q       <= wdog_d;
         hold_full_q  <= hold_full_d;
         hold_q       <= hold_d;
      end
   end

   assign state      = state_q;
   assign cmp_start  = cmp_start_q;
   assign cmp_x      = cmp_x_q;
   assign dac_tdata  = dac_tdata_q;
   assign dac_tvalid = dac_tvalid_q;
   assign ovr_cnt    = ovr_cnt_q;
   assign to_cnt     = to_cnt_q;

endmodule
